// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage MIPS pipeline: turns hazard,
// cache and branch status into per-stage latch enables/flushes, and keeps stall/flush counters.
module pipeline_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             lu_stall,
  input  logic             branch_taken,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } ctrlState_t;

  ctrlState_t state;
  ctrlState_t nextState;
  logic       memBusy;
  logic       branchFlush;

  // Outstanding data access: a fresh miss in RUN, or an unfinished one in DWAIT.
  always_comb begin
    memBusy = 1'b0;
    case (state)
      RUN:     memBusy = dmem_req & ~dhit;
      DWAIT:   memBusy = ~dhit;
      default: memBusy = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    nextState   = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    branchFlush = 1'b0;
    halted      = (state == HALT);

    if (!RST && state != HALT) begin
      if (state == RUN && halt_wb) begin
        nextState = HALT;
      end else if (memBusy) begin
        // Freeze the front of the pipe and push a bubble into WB.
        nextState   = DWAIT;
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else begin
        nextState = RUN;
        if (branch_taken) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          branchFlush = 1'b1;
        end else if (lu_stall) begin
          // Load-use wins over a fetch miss: IF/ID holds its instruction.
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end else if (!ihit) begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= nextState;
      if (!pc_en && state != HALT && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (branchFlush && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
